// File: rtl/ulpi_rx_receiver.sv
// ULPI receive-side link engine.
// Owns the bus whenever the PHY drives DIR high and handles the turnaround
// cycles. Splits the PHY byte stream into RX CMD status updates and packet
// data bytes, frames packets, counts their length and flags errors.
// BUSY tells the transmit side when it must not drive DATA.
module ulpi_rx_receiver #(
    parameter int MAX_PKT_LEN = 1024,
    parameter int LEN_W       = 16
) (
    input  logic             CLK_USB,
    input  logic             SYS_RST,
    input  logic             DIR,
    input  logic             NXT,
    input  logic [7:0]       DATA_IN,
    output logic             BUSY,
    output logic [7:0]       RX_DATA,
    output logic             RX_VALID,
    output logic             RX_ACTIVE,
    output logic             PKT_END,
    output logic [LEN_W-1:0] PKT_LEN,
    output logic             RX_ERROR,
    output logic             OVERFLOW,
    output logic [1:0]       LINE_STATE,
    output logic [1:0]       VBUS_STATE,
    output logic             RXCMD_VALID,
    output logic             HOST_DISC
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_TURN_IN  = 2'd1;
    localparam logic [1:0] ST_RECV     = 2'd2;
    localparam logic [1:0] ST_TURN_OUT = 2'd3;

    localparam logic [LEN_W-1:0] MAX_LEN_C = LEN_W'(MAX_PKT_LEN);
    localparam logic [LEN_W-1:0] ONE_C     = LEN_W'(1);
    localparam logic [LEN_W-1:0] ZERO_C    = {LEN_W{1'b0}};

    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic [LEN_W-1:0] count_r;
    logic [7:0]       rx_data_r;
    logic             rx_valid_r;
    logic             rx_active_r;
    logic             pkt_end_r;
    logic [LEN_W-1:0] pkt_len_r;
    logic             rx_error_r;
    logic             overflow_r;
    logic [1:0]       line_state_r;
    logic [1:0]       vbus_state_r;
    logic             rxcmd_valid_r;
    logic             host_disc_r;

    logic             rxcmd_s;
    logic             data_s;
    logic             abort_s;
    logic [1:0]       rx_event_s;

    // Next-state logic for the bus ownership / turnaround sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (DIR) begin
                    state_nxt_s = ST_TURN_IN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_TURN_IN: begin
                if (DIR) begin
                    state_nxt_s = ST_RECV;
                end else begin
                    state_nxt_s = ST_TURN_OUT;
                end
            end
            ST_RECV: begin
                if (DIR) begin
                    state_nxt_s = ST_RECV;
                end else begin
                    state_nxt_s = ST_TURN_OUT;
                end
            end
            ST_TURN_OUT: begin
                if (DIR) begin
                    state_nxt_s = ST_TURN_IN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Classify the current bus cycle; only RECV cycles with DIR high carry
    // information, and DIR low in RECV with an open packet is an abort.
    always_comb begin
        rx_event_s = DATA_IN[5:4];
        if (state_r == ST_RECV) begin
            rxcmd_s = DIR & ~NXT;
            data_s  = DIR & NXT;
            abort_s = ~DIR & rx_active_r;
        end else begin
            rxcmd_s = 1'b0;
            data_s  = 1'b0;
            abort_s = 1'b0;
        end
    end

    // BUSY must react in the same cycle DIR rises, so it is combinational.
    always_comb begin
        if (DIR || (state_r != ST_IDLE)) begin
            BUSY = 1'b1;
        end else begin
            BUSY = 1'b0;
        end
    end

    // Sequencer state, packet framing, length counting and status registers.
    always_ff @(posedge CLK_USB) begin
        if (SYS_RST) begin
            state_r       <= ST_IDLE;
            count_r       <= ZERO_C;
            rx_data_r     <= 8'h00;
            rx_valid_r    <= 1'b0;
            rx_active_r   <= 1'b0;
            pkt_end_r     <= 1'b0;
            pkt_len_r     <= ZERO_C;
            rx_error_r    <= 1'b0;
            overflow_r    <= 1'b0;
            line_state_r  <= 2'b00;
            vbus_state_r  <= 2'b00;
            rxcmd_valid_r <= 1'b0;
            host_disc_r   <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            rx_valid_r    <= 1'b0;
            pkt_end_r     <= 1'b0;
            rxcmd_valid_r <= 1'b0;
            if (rxcmd_s) begin
                line_state_r  <= DATA_IN[1:0];
                vbus_state_r  <= DATA_IN[3:2];
                rxcmd_valid_r <= 1'b1;
                host_disc_r   <= (rx_event_s == 2'b10);
                case (rx_event_s)
                    2'b01, 2'b11: begin
                        rx_active_r <= 1'b1;
                        if (!rx_active_r) begin
                            // Packet start: a fresh count and fresh status,
                            // except an RxError on the opening command.
                            count_r    <= ZERO_C;
                            overflow_r <= 1'b0;
                            rx_error_r <= (rx_event_s == 2'b11);
                        end else if (rx_event_s == 2'b11) begin
                            rx_error_r <= 1'b1;
                        end else begin
                            rx_error_r <= rx_error_r;
                        end
                    end
                    2'b00: begin
                        rx_active_r <= 1'b0;
                        if (rx_active_r) begin
                            pkt_end_r <= 1'b1;
                            pkt_len_r <= count_r;
                        end else begin
                            pkt_len_r <= pkt_len_r;
                        end
                    end
                    default: begin
                        // Host disconnect leaves packet framing untouched.
                        rx_active_r <= rx_active_r;
                    end
                endcase
            end else if (data_s) begin
                if (rx_active_r && (count_r < MAX_LEN_C)) begin
                    rx_data_r  <= DATA_IN;
                    rx_valid_r <= 1'b1;
                    count_r    <= count_r + ONE_C;
                end else if (rx_active_r) begin
                    // Count saturates at the limit; excess bytes are dropped.
                    overflow_r <= 1'b1;
                    rx_error_r <= 1'b1;
                end else begin
                    // Data outside a packet is silently ignored.
                    count_r <= count_r;
                end
            end else if (abort_s) begin
                // PHY released the bus mid-packet: close it as errored.
                rx_active_r <= 1'b0;
                pkt_end_r   <= 1'b1;
                pkt_len_r   <= count_r;
                rx_error_r  <= 1'b1;
            end else begin
                count_r <= count_r;
            end
        end
    end

    assign RX_DATA     = rx_data_r;
    assign RX_VALID    = rx_valid_r;
    assign RX_ACTIVE   = rx_active_r;
    assign PKT_END     = pkt_end_r;
    assign PKT_LEN     = pkt_len_r;
    assign RX_ERROR    = rx_error_r;
    assign OVERFLOW    = overflow_r;
    assign LINE_STATE  = line_state_r;
    assign VBUS_STATE  = vbus_state_r;
    assign RXCMD_VALID = rxcmd_valid_r;
    assign HOST_DISC   = host_disc_r;

endmodule

// File: tb/tb_ulpi_rx_receiver.sv
// Directed testbench for ulpi_rx_receiver with a small packet limit so the
// overflow path is reachable.
module tb_ulpi_rx_receiver;

    localparam int MAX_PKT_LEN = 4;
    localparam int LEN_W       = 16;

    logic             CLK_USB;
    logic             SYS_RST;
    logic             DIR;
    logic             NXT;
    logic [7:0]       DATA_IN;
    logic             BUSY;
    logic [7:0]       RX_DATA;
    logic             RX_VALID;
    logic             RX_ACTIVE;
    logic             PKT_END;
    logic [LEN_W-1:0] PKT_LEN;
    logic             RX_ERROR;
    logic             OVERFLOW;
    logic [1:0]       LINE_STATE;
    logic [1:0]       VBUS_STATE;
    logic             RXCMD_VALID;
    logic             HOST_DISC;

    int n_cmp = 0;
    int n_err = 0;
    int n_valid = 0;

    ulpi_rx_receiver #(
        .MAX_PKT_LEN (MAX_PKT_LEN),
        .LEN_W       (LEN_W)
    ) dut (
        .CLK_USB     (CLK_USB),
        .SYS_RST     (SYS_RST),
        .DIR         (DIR),
        .NXT         (NXT),
        .DATA_IN     (DATA_IN),
        .BUSY        (BUSY),
        .RX_DATA     (RX_DATA),
        .RX_VALID    (RX_VALID),
        .RX_ACTIVE   (RX_ACTIVE),
        .PKT_END     (PKT_END),
        .PKT_LEN     (PKT_LEN),
        .RX_ERROR    (RX_ERROR),
        .OVERFLOW    (OVERFLOW),
        .LINE_STATE  (LINE_STATE),
        .VBUS_STATE  (VBUS_STATE),
        .RXCMD_VALID (RXCMD_VALID),
        .HOST_DISC   (HOST_DISC)
    );

    // 60 MHz-style free-running clock.
    initial begin
        CLK_USB = 1'b0;
        forever #5 CLK_USB = ~CLK_USB;
    end

    // Guard against a stuck run.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_bus(input logic d, input logic n, input logic [7:0] x);
        DIR = d;
        NXT = n;
        DATA_IN = x;
        #1;
    endtask

    task automatic tick();
        @(posedge CLK_USB);
        #1;
    endtask

    task automatic cyc(input logic d, input logic n, input logic [7:0] x);
        set_bus(d, n, x);
        tick();
    endtask

    // IDLE -> TURN_IN -> RECV
    task automatic open_bus();
        cyc(1'b1, 1'b0, 8'h00);
        cyc(1'b1, 1'b0, 8'h00);
    endtask

    // RECV -> TURN_OUT -> IDLE
    task automatic close_bus();
        cyc(1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        SYS_RST = 1'b1;
        DIR = 1'b0;
        NXT = 1'b0;
        DATA_IN = 8'h00;
        tick();
        tick();

        // Reset state
        chk("rst_busy", BUSY, 32'd0);
        chk("rst_active", RX_ACTIVE, 32'd0);
        chk("rst_valid", RX_VALID, 32'd0);
        chk("rst_pkt_end", PKT_END, 32'd0);
        chk("rst_pkt_len", PKT_LEN, 32'd0);
        chk("rst_err", RX_ERROR, 32'd0);
        chk("rst_ovf", OVERFLOW, 32'd0);
        chk("rst_line", LINE_STATE, 32'd0);
        SYS_RST = 1'b0;

        // 1: turnaround byte ignored; BUSY immediate
        set_bus(1'b1, 1'b1, 8'hFF);
        chk("t1_busy_first", BUSY, 32'd1);
        tick();
        chk("t1_valid_a", RX_VALID, 32'd0);
        cyc(1'b1, 1'b1, 8'hFF);
        chk("t1_valid_turn", RX_VALID, 32'd0);
        chk("t1_cmd_turn", RXCMD_VALID, 32'd0);
        chk("t1_busy_recv", BUSY, 32'd1);
        close_bus();
        chk("t1_busy_idle", BUSY, 32'd0);

        // 2: basic packet of 3 bytes
        open_bus();
        cyc(1'b1, 1'b0, 8'h11);
        chk("t2_cmd_valid", RXCMD_VALID, 32'd1);
        chk("t2_active", RX_ACTIVE, 32'd1);
        chk("t2_line", LINE_STATE, 32'd1);
        chk("t2_valid_cmd", RX_VALID, 32'd0);
        cyc(1'b1, 1'b1, 8'hC3);
        chk("t2_v0", RX_VALID, 32'd1);
        chk("t2_d0", RX_DATA, 32'hC3);
        cyc(1'b1, 1'b1, 8'hA5);
        chk("t2_v1", RX_VALID, 32'd1);
        chk("t2_d1", RX_DATA, 32'hA5);
        cyc(1'b1, 1'b1, 8'h5A);
        chk("t2_v2", RX_VALID, 32'd1);
        chk("t2_d2", RX_DATA, 32'h5A);
        cyc(1'b1, 1'b0, 8'h01);
        chk("t2_pkt_end", PKT_END, 32'd1);
        chk("t2_pkt_len", PKT_LEN, 32'd3);
        chk("t2_active_off", RX_ACTIVE, 32'd0);
        chk("t2_err", RX_ERROR, 32'd0);
        chk("t2_cmd_and_end", RXCMD_VALID, 32'd1);
        chk("t2_line_end", LINE_STATE, 32'd1);
        cyc(1'b1, 1'b1, 8'h77);
        chk("t2_drop_idle", RX_VALID, 32'd0);
        chk("t2_end_strobe", PKT_END, 32'd0);
        chk("t2_len_held", PKT_LEN, 32'd3);

        // 3: packet opened with RxError
        cyc(1'b1, 1'b0, 8'h31);
        chk("t3_active", RX_ACTIVE, 32'd1);
        chk("t3_err_open", RX_ERROR, 32'd1);
        cyc(1'b1, 1'b1, 8'h10);
        chk("t3_v0", RX_VALID, 32'd1);
        cyc(1'b1, 1'b1, 8'h20);
        chk("t3_d1", RX_DATA, 32'h20);
        cyc(1'b1, 1'b0, 8'h00);
        chk("t3_pkt_end", PKT_END, 32'd1);
        chk("t3_pkt_len", PKT_LEN, 32'd2);
        chk("t3_err_end", RX_ERROR, 32'd1);
        chk("t3_line0", LINE_STATE, 32'd0);
        cyc(1'b1, 1'b0, 8'h15);
        chk("t3_err_clear", RX_ERROR, 32'd0);
        chk("t3_active2", RX_ACTIVE, 32'd1);
        chk("t3_vbus", VBUS_STATE, 32'd1);

        // 4: overflow at MAX_PKT_LEN=4 with 6 bytes
        n_valid = 0;
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, 1'b1, 8'(i + 1));
            if (RX_VALID === 1'b1) n_valid++;
            if (i < 4) begin
                chk("t4_data", RX_DATA, 32'(i + 1));
                chk("t4_ovf_lo", OVERFLOW, 32'd0);
            end else begin
                chk("t4_ovf_hi", OVERFLOW, 32'd1);
                chk("t4_err_hi", RX_ERROR, 32'd1);
                chk("t4_data_hold", RX_DATA, 32'd4);
            end
        end
        chk("t4_valid_count", 32'(n_valid), 32'd4);
        cyc(1'b1, 1'b0, 8'h01);
        chk("t4_pkt_end", PKT_END, 32'd1);
        chk("t4_pkt_len", PKT_LEN, 32'd4);
        chk("t4_ovf_end", OVERFLOW, 32'd1);
        chk("t4_err_end", RX_ERROR, 32'd1);

        // Host disconnect event
        cyc(1'b1, 1'b0, 8'h20);
        chk("hd_set", HOST_DISC, 32'd1);
        chk("hd_no_active", RX_ACTIVE, 32'd0);
        chk("hd_no_end", PKT_END, 32'd0);

        // 5: abort by DIR falling, byte on the falling cycle not captured
        cyc(1'b1, 1'b0, 8'h11);
        chk("t5_hd_clear", HOST_DISC, 32'd0);
        chk("t5_ovf_clear", OVERFLOW, 32'd0);
        chk("t5_err_clear", RX_ERROR, 32'd0);
        cyc(1'b1, 1'b1, 8'hAA);
        cyc(1'b1, 1'b1, 8'hBB);
        chk("t5_d1", RX_DATA, 32'hBB);
        set_bus(1'b0, 1'b1, 8'hCC);
        chk("t5_busy_dirfall", BUSY, 32'd1);
        tick();
        chk("t5_pkt_end", PKT_END, 32'd1);
        chk("t5_pkt_len", PKT_LEN, 32'd2);
        chk("t5_err", RX_ERROR, 32'd1);
        chk("t5_no_capture", RX_VALID, 32'd0);
        chk("t5_data_kept", RX_DATA, 32'hBB);
        chk("t5_active_off", RX_ACTIVE, 32'd0);
        chk("t5_busy_turnout", BUSY, 32'd1);
        cyc(1'b0, 1'b0, 8'h00);
        chk("t5_busy_idle", BUSY, 32'd0);
        chk("t5_end_strobe", PKT_END, 32'd0);

        // 6: reset mid-packet
        open_bus();
        cyc(1'b1, 1'b0, 8'h11);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b1, 8'h40 + 8'(i));
        end
        chk("t6_pre_ovf", OVERFLOW, 32'd1);
        SYS_RST = 1'b1;
        cyc(1'b0, 1'b0, 8'h00);
        chk("t6_active", RX_ACTIVE, 32'd0);
        chk("t6_pkt_end", PKT_END, 32'd0);
        chk("t6_pkt_len", PKT_LEN, 32'd0);
        chk("t6_ovf", OVERFLOW, 32'd0);
        chk("t6_err", RX_ERROR, 32'd0);
        chk("t6_data", RX_DATA, 32'd0);
        chk("t6_line", LINE_STATE, 32'd0);
        chk("t6_busy", BUSY, 32'd0);
        SYS_RST = 1'b0;
        tick();
        chk("t6_no_late_end", PKT_END, 32'd0);
        open_bus();
        cyc(1'b1, 1'b0, 8'h11);
        cyc(1'b1, 1'b1, 8'h01);
        cyc(1'b1, 1'b1, 8'h02);
        cyc(1'b1, 1'b0, 8'h01);
        chk("t6_new_end", PKT_END, 32'd1);
        chk("t6_new_len", PKT_LEN, 32'd2);
        chk("t6_new_err", RX_ERROR, 32'd0);
        close_bus();
        chk("t6_busy_done", BUSY, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ulpi_rx_receiver.md
Name: ulpi_rx_receiver

Overview:
Receive-side ULPI link engine. It takes the bus from the PHY whenever DIR is high, handles turnaround cycles, and splits the PHY byte stream into RX CMD status updates and USB packet data bytes. It frames packets, counts their length and reports errors. It sits beside the transmit state machine in the USB module and gives it a BUSY flag so the transmitter never drives DATA while the PHY owns the bus.

Parameters:
MAX_PKT_LEN, 1024, maximum data bytes accepted per packet; further bytes are dropped and flagged as overflow.
LEN_W, 16, width of the packet length counter and the PKT_LEN output.

Ports:
CLK_USB  input  1  ULPI 60 MHz clock from PHY; all logic on rising edge
SYS_RST  input  1  synchronous active-high reset
DIR  input  1  PHY bus direction; 1 = PHY drives DATA_IN
NXT  input  1  PHY next; while DIR=1, 1 = data byte, 0 = RX CMD byte
DATA_IN  input  8  ULPI data bus as seen by the link
BUSY  output  1  PHY owns the bus (DIR high or in turnaround); transmit side must hold off
RX_DATA  output  8  received packet byte
RX_VALID  output  1  RX_DATA valid, one-cycle strobe per byte
RX_ACTIVE  output  1  packet in progress
PKT_END  output  1  one-cycle strobe when a packet closes
PKT_LEN  output  LEN_W  byte count of the closed packet; valid while PKT_END=1, held afterwards
RX_ERROR  output  1  sticky per packet: PHY RxError or overflow seen; cleared when the next packet starts
OVERFLOW  output  1  sticky per packet: more than MAX_PKT_LEN bytes seen
LINE_STATE  output  2  last RX CMD bits[1:0]
VBUS_STATE  output  2  last RX CMD bits[3:2]
RXCMD_VALID  output  1  one-cycle strobe when an RX CMD is decoded
HOST_DISC  output  1  last RX CMD RxEvent == 2'b10

Behaviour:
- Reset: all outputs 0, FSM in IDLE, length counter 0. A reset in the middle of a packet drops the packet silently; no PKT_END is issued.
- FSM states: IDLE, TURN_IN, RECV, TURN_OUT.
  - IDLE: if DIR=1, go to TURN_IN.
  - TURN_IN: lasts exactly one cycle. DATA_IN is ignored regardless of NXT. Go to RECV if DIR=1, otherwise TURN_OUT.
  - RECV: every cycle with DIR=1 is decoded (see below). When DIR=0, go to TURN_OUT.
  - TURN_OUT: lasts one cycle, DATA_IN ignored. Go to IDLE, or to TURN_IN if DIR=1 again.
- BUSY = 1 in TURN_IN, RECV and TURN_OUT, and combinationally whenever DIR=1.
- Decode in RECV; all outputs are registered, so latency is 1 cycle from the sampled bus cycle.
  - NXT=0 (RX CMD):
    - LINE_STATE <= DATA_IN[1:0]; VBUS_STATE <= DATA_IN[3:2]; RXCMD_VALID=1.
    - RxEvent = DATA_IN[5:4]. 01 sets RX_ACTIVE. 11 sets RX_ACTIVE and RX_ERROR. 10 sets HOST_DISC. 00 clears RX_ACTIVE.
    - RX_ACTIVE going 1->0 closes the packet.
  - NXT=1 (data):
    - If RX_ACTIVE=1 and count < MAX_PKT_LEN: RX_DATA <= DATA_IN, RX_VALID=1, count+1.
    - If RX_ACTIVE=1 and count == MAX_PKT_LEN: byte dropped, OVERFLOW=1, RX_ERROR=1; count saturates.
    - If RX_ACTIVE=0: byte dropped, no error.
- Packet start: the cycle RX_ACTIVE rises 0->1. Count is cleared and RX_ERROR/OVERFLOW are cleared on that same cycle, unless that same RX CMD is RxError, in which case RX_ERROR ends up 1.
- Packet close, triggered by either:
  - an RX CMD with RxEvent 00, or
  - DIR falling while RX_ACTIVE=1 (abort); this also sets RX_ERROR.
  - On close: PKT_END=1 for one cycle, PKT_LEN <= count, RX_ACTIVE <= 0.
- Simultaneous events:
  - DIR falling in the same cycle as a data byte: the byte is not captured. DIR=0 means the link owns the bus.
  - PKT_END and RXCMD_VALID may assert in the same cycle.
- Width: the count is LEN_W bits. MAX_PKT_LEN must be below 2^LEN_W, so the counter never wraps.

Test Plan:
1. Reset, then DIR=1; TURN_IN cycle carries DATA_IN=0xFF with NXT=1 -> no RX_VALID; BUSY=1 from the first DIR cycle.
2. DIR=1 turnaround; RX CMD 0x11; data bytes 0xC3, 0xA5, 0x5A (NXT=1); RX CMD 0x01 -> RX_VALID three times with those values, RX_ACTIVE 1 then 0, PKT_END with PKT_LEN=3, RX_ERROR=0, LINE_STATE=01.
3. Open a packet with RX CMD 0x31 (RxError), then 2 data bytes, then RX CMD 0x00 -> RX_ERROR=1, PKT_LEN=2; next packet start clears RX_ERROR.
4. MAX_PKT_LEN=4; send 6 data bytes then close -> exactly 4 RX_VALID, OVERFLOW=1, RX_ERROR=1, PKT_LEN=4.
5. After RX CMD 0x11 and 2 data bytes, drop DIR -> PKT_END, PKT_LEN=2, RX_ERROR=1, TURN_OUT cycle, BUSY falls one cycle after DIR.
6. Assert SYS_RST mid-packet after 5 bytes -> all outputs 0 next cycle, no PKT_END; the next packet reports its own length from 0.
